// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcode field layout, access size
// codes, the FSM state type and the alignment helper.
package mem_stage_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  // mem_opt = {is_store, is_unsigned, size[1:0]}
  localparam int OPT_STORE   = 3;
  localparam int OPT_UNS     = 2;
  localparam int OPT_SIZE_HI = 1;
  localparam int OPT_SIZE_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
    unique case (size)
      MEM_SIZE_B: misaligned = 1'b0;
      MEM_SIZE_H: misaligned = lo[0];
      MEM_SIZE_W: misaligned = |lo[1:0];
      default:    misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Byte-lane formatting for the 8-byte data bus: store shift/strobe generation
// and load lane extraction with sign/zero extension.
module mem_lane
  import mem_stage_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic [1:0]           size,
  input  logic                 uns,
  input  logic [2:0]           offset,
  input  logic [CPU_WIDTH-1:0] store_data,
  input  logic [CPU_WIDTH-1:0] rdata,
  output logic [CPU_WIDTH-1:0] wdata,
  output logic [7:0]           wstrb,
  output logic [CPU_WIDTH-1:0] load_data
);

  logic [5:0]           bit_off;
  logic [CPU_WIDTH-1:0] lane;
  logic [7:0]           mask;

  assign bit_off = {offset, 3'b000};
  assign wdata   = store_data << bit_off;
  assign lane    = rdata >> bit_off;
  assign wstrb   = mask << offset;

  always_comb begin
    mask      = 8'h00;
    load_data = '0;
    unique case (size)
      MEM_SIZE_B: begin
        mask      = 8'h01;
        load_data = uns ? {{(CPU_WIDTH-8){1'b0}}, lane[7:0]}
                        : {{(CPU_WIDTH-8){lane[7]}}, lane[7:0]};
      end
      MEM_SIZE_H: begin
        mask      = 8'h03;
        load_data = uns ? {{(CPU_WIDTH-16){1'b0}}, lane[15:0]}
                        : {{(CPU_WIDTH-16){lane[15]}}, lane[15:0]};
      end
      MEM_SIZE_W: begin
        mask      = 8'h0F;
        load_data = uns ? {{(CPU_WIDTH-32){1'b0}}, lane[31:0]}
                        : {{(CPU_WIDTH-32){lane[31]}}, lane[31:0]};
      end
      default: begin
        mask      = 8'hFF;
        load_data = lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts one executed instruction from EXU, runs at most one
// data-bus transaction for it, and holds the result for write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CPU_WIDTH     = 64,
  parameter int MEM_OPT_WIDTH = 4,
  parameter int RD_WIDTH      = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     alu_mem_valid,
  output logic                     mem_alu_ready,
  input  logic [CPU_WIDTH-1:0]     i_exu_res,
  input  logic [CPU_WIDTH-1:0]     i_rs2,
  input  logic                     i_mem_en,
  input  logic [MEM_OPT_WIDTH-1:0] i_mem_opt,
  input  logic [RD_WIDTH-1:0]      i_rd,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic [CPU_WIDTH-1:0]     o_req_addr,
  output logic                     o_req_wen,
  output logic [CPU_WIDTH-1:0]     o_req_wdata,
  output logic [7:0]               o_req_wstrb,
  input  logic                     i_rsp_valid,
  input  logic [CPU_WIDTH-1:0]     i_rsp_rdata,
  output logic                     mem_wb_valid,
  input  logic                     wb_mem_ready,
  output logic [CPU_WIDTH-1:0]     o_wb_data,
  output logic [RD_WIDTH-1:0]      o_wb_rd,
  output logic                     o_wb_wen,
  output logic                     o_misalign
);

  mem_state_t state, state_nxt;

  logic [CPU_WIDTH-1:0]     addr;
  logic [CPU_WIDTH-1:0]     store_data;
  logic [MEM_OPT_WIDTH-1:0] opt;
  logic [RD_WIDTH-1:0]      rd;
  logic [CPU_WIDTH-1:0]     wb_data;
  logic                     wb_wen;
  logic                     misalign;

  logic                 accept;
  logic                 mis_in;
  logic                 is_store;
  logic [CPU_WIDTH-1:0] lane_wdata;
  logic [7:0]           lane_wstrb;
  logic [CPU_WIDTH-1:0] load_data;

  assign accept   = alu_mem_valid & mem_alu_ready;
  assign mis_in   = misaligned(i_exu_res[2:0], i_mem_opt[OPT_SIZE_HI:OPT_SIZE_LO]);
  assign is_store = opt[OPT_STORE];

  mem_lane #(.CPU_WIDTH(CPU_WIDTH)) u_lane (
    .size       (opt[OPT_SIZE_HI:OPT_SIZE_LO]),
    .uns        (opt[OPT_UNS]),
    .offset     (addr[2:0]),
    .store_data (store_data),
    .rdata      (i_rsp_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (i_mem_en && !mis_in) ? REQ : HOLD;
      REQ:  if (i_req_ready) state_nxt = RESP;
      RESP: if (i_rsp_valid) state_nxt = HOLD;
      HOLD: if (wb_mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr       <= '0;
      store_data <= '0;
      opt        <= '0;
      rd         <= '0;
      wb_data    <= '0;
      wb_wen     <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign <= accept & i_mem_en & mis_in;
      if (accept) begin
        addr       <= i_exu_res;
        store_data <= i_rs2;
        opt        <= i_mem_opt;
        rd         <= i_rd;
        // memory ops (including dropped misaligned ones) start with no write-back
        wb_data    <= i_mem_en ? '0 : i_exu_res;
        wb_wen     <= ~i_mem_en;
      end else if (state == RESP && i_rsp_valid) begin
        wb_data <= is_store ? '0 : load_data;
        wb_wen  <= ~is_store;
      end
    end
  end

  assign mem_alu_ready = (state == IDLE);
  assign mem_wb_valid  = (state == HOLD);
  assign o_req_valid   = (state == REQ);
  assign o_req_addr    = {addr[CPU_WIDTH-1:3], 3'b000};
  assign o_req_wen     = is_store;
  assign o_req_wdata   = is_store ? lane_wdata : '0;
  assign o_req_wstrb   = is_store ? lane_wstrb : 8'h00;
  assign o_wb_data     = wb_data;
  assign o_wb_rd       = rd;
  assign o_wb_wen      = wb_wen;
  assign o_misalign    = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, backpressure,
// misaligned drop, back-to-back throughput and mid-transaction reset.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        alu_mem_valid;
  logic        mem_alu_ready;
  logic [63:0] i_exu_res;
  logic [63:0] i_rs2;
  logic        i_mem_en;
  logic [3:0]  i_mem_opt;
  logic [4:0]  i_rd;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [63:0] o_req_addr;
  logic        o_req_wen;
  logic [63:0] o_req_wdata;
  logic [7:0]  o_req_wstrb;
  logic        i_rsp_valid;
  logic [63:0] i_rsp_rdata;
  logic        mem_wb_valid;
  logic        wb_mem_ready;
  logic [63:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_wen;
  logic        o_misalign;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .alu_mem_valid(alu_mem_valid), .mem_alu_ready(mem_alu_ready),
    .i_exu_res(i_exu_res), .i_rs2(i_rs2), .i_mem_en(i_mem_en),
    .i_mem_opt(i_mem_opt), .i_rd(i_rd),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_addr(o_req_addr), .o_req_wen(o_req_wen),
    .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .mem_wb_valid(mem_wb_valid), .wb_mem_ready(wb_mem_ready),
    .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_wen(o_wb_wen),
    .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] exu, input logic [63:0] rs2, input logic en,
                       input logic [3:0] opt, input logic [4:0] rd);
    i_exu_res = exu; i_rs2 = rs2; i_mem_en = en; i_mem_opt = opt; i_rd = rd;
    alu_mem_valid = 1'b1;
    tick();
    alu_mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (mem_alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", mem_alu_ready); end
    checks++; if ({o_req_valid, mem_wb_valid, o_wb_wen, o_misalign, o_req_wen} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %05b want 00000", {o_req_valid, mem_wb_valid, o_wb_wen, o_misalign, o_req_wen}); end
    checks++; if ({o_wb_data, o_req_addr, o_req_wdata, o_req_wstrb, o_wb_rd} !== '0) begin
      errors++; $display("FAIL reset_data got wb=%h addr=%h wd=%h ws=%h rd=%h want all 0",
                         o_wb_data, o_req_addr, o_req_wdata, o_req_wstrb, o_wb_rd); end
  endtask

  task automatic test_passthrough();
    issue(64'h1234, 64'h0, 1'b0, 4'h0, 5'd7);
    for (int c = 0; c < 4; c++) begin
      checks++; if ({mem_wb_valid, o_wb_wen, mem_alu_ready, o_req_valid} !== 4'b1100) begin
        errors++; $display("FAIL pass_ctrl cyc%0d got %04b want 1100", c, {mem_wb_valid, o_wb_wen, mem_alu_ready, o_req_valid}); end
      checks++; if (o_wb_data !== 64'h1234 || o_wb_rd !== 5'd7) begin
        errors++; $display("FAIL pass_data cyc%0d got %h/%0d want 1234/7", c, o_wb_data, o_wb_rd); end
      if (c < 3) tick();
    end
    wb_mem_ready = 1'b1;
    tick();
    wb_mem_ready = 1'b0;
    checks++; if (mem_alu_ready !== 1'b1 || mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL pass_release got ready=%0b valid=%0b want 1/0", mem_alu_ready, mem_wb_valid); end
  endtask

  task automatic test_loads();
    logic [63:0] addr_t [3] = '{64'h8000_0003, 64'h1002, 64'h104};
    logic [3:0]  opt_t  [3] = '{4'b0000, 4'b0101, 4'b0010};
    logic [63:0] rd_t   [3] = '{64'h0000_0000_8000_0000, 64'h0000_0000_F00D_0000, 64'h8765_4321_0000_0000};
    logic [63:0] exp_t  [3] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_F00D, 64'hFFFF_FFFF_8765_4321};
    logic [63:0] base_t [3] = '{64'h8000_0000, 64'h1000, 64'h100};
    for (int i = 0; i < 3; i++) begin
      issue(addr_t[i], 64'hFFFF, 1'b1, opt_t[i], 5'd5);
      checks++; if (o_req_valid !== 1'b1 || o_req_addr !== base_t[i] || o_req_wen !== 1'b0) begin
        errors++; $display("FAIL load%0d_req got v=%0b addr=%h wen=%0b want 1/%h/0", i, o_req_valid, o_req_addr, o_req_wen, base_t[i]); end
      checks++; if (o_req_wstrb !== 8'h00 || o_req_wdata !== 64'h0) begin
        errors++; $display("FAIL load%0d_wfields got ws=%h wd=%h want 0/0", i, o_req_wstrb, o_req_wdata); end
      i_req_ready = 1'b1;
      tick();
      i_req_ready = 1'b0;
      checks++; if (o_req_valid !== 1'b0 || mem_wb_valid !== 1'b0) begin
        errors++; $display("FAIL load%0d_resp_wait got req=%0b wbv=%0b want 0/0", i, o_req_valid, mem_wb_valid); end
      i_rsp_valid = 1'b1; i_rsp_rdata = rd_t[i];
      tick();
      i_rsp_valid = 1'b0; i_rsp_rdata = 64'h0;
      checks++; if (mem_wb_valid !== 1'b1 || o_wb_wen !== 1'b1 || o_wb_data !== exp_t[i] || o_wb_rd !== 5'd5) begin
        errors++; $display("FAIL load%0d_data got v=%0b wen=%0b d=%h rd=%0d want 1/1/%h/5", i, mem_wb_valid, o_wb_wen, o_wb_data, o_wb_rd, exp_t[i]); end
      wb_mem_ready = 1'b1;
      tick();
      wb_mem_ready = 1'b0;
    end
  endtask

  task automatic test_stores();
    logic [63:0] addr_t [3] = '{64'h8000_0006, 64'h8000_0008, 64'h4};
    logic [3:0]  opt_t  [3] = '{4'b1001, 4'b1011, 4'b1010};
    logic [63:0] rs2_t  [3] = '{64'hABCD, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF};
    logic [63:0] wd_t   [3] = '{64'hABCD_0000_0000_0000, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0000};
    logic [7:0]  ws_t   [3] = '{8'hC0, 8'hFF, 8'hF0};
    logic [63:0] base_t [3] = '{64'h8000_0000, 64'h8000_0008, 64'h0};
    for (int i = 0; i < 3; i++) begin
      issue(addr_t[i], rs2_t[i], 1'b1, opt_t[i], 5'd9);
      checks++; if (o_req_valid !== 1'b1 || o_req_wen !== 1'b1 || o_req_addr !== base_t[i]) begin
        errors++; $display("FAIL store%0d_req got v=%0b wen=%0b addr=%h want 1/1/%h", i, o_req_valid, o_req_wen, o_req_addr, base_t[i]); end
      checks++; if (o_req_wdata !== wd_t[i] || o_req_wstrb !== ws_t[i]) begin
        errors++; $display("FAIL store%0d_fmt got wd=%h ws=%h want %h/%h", i, o_req_wdata, o_req_wstrb, wd_t[i], ws_t[i]); end
      i_req_ready = 1'b1;
      tick();
      i_req_ready = 1'b0;
      i_rsp_valid = 1'b1;
      tick();
      i_rsp_valid = 1'b0;
      checks++; if (mem_wb_valid !== 1'b1 || o_wb_wen !== 1'b0 || o_wb_data !== 64'h0) begin
        errors++; $display("FAIL store%0d_ack got v=%0b wen=%0b d=%h want 1/0/0", i, mem_wb_valid, o_wb_wen, o_wb_data); end
      wb_mem_ready = 1'b1;
      tick();
      wb_mem_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    issue(64'h2005, 64'h5A, 1'b1, 4'b1000, 5'd3);
    for (int c = 0; c < 4; c++) begin
      checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h2000 || o_req_wdata !== 64'h0000_5A00_0000_0000 || o_req_wstrb !== 8'h20) begin
        errors++; $display("FAIL bp_hold cyc%0d got v=%0b addr=%h wd=%h ws=%h want 1/2000/00005a0000000000/20",
                           c, o_req_valid, o_req_addr, o_req_wdata, o_req_wstrb); end
      i_rsp_valid = (c == 1);
      tick();
      i_rsp_valid = 1'b0;
    end
    checks++; if (o_req_valid !== 1'b1 || mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL bp_rsp_ignored got req=%0b wbv=%0b want 1/0", o_req_valid, mem_wb_valid); end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1;
    tick();
    i_rsp_valid = 1'b0;
    checks++; if (mem_wb_valid !== 1'b1 || o_wb_wen !== 1'b0) begin
      errors++; $display("FAIL bp_done got v=%0b wen=%0b want 1/0", mem_wb_valid, o_wb_wen); end
    wb_mem_ready = 1'b1;
    tick();
    wb_mem_ready = 1'b0;
  endtask

  task automatic test_misalign();
    issue(64'h8000_1002, 64'h77, 1'b1, 4'b0010, 5'd4);
    checks++; if (o_misalign !== 1'b1 || o_req_valid !== 1'b0) begin
      errors++; $display("FAIL mis_pulse got mis=%0b req=%0b want 1/0", o_misalign, o_req_valid); end
    checks++; if (mem_wb_valid !== 1'b1 || o_wb_wen !== 1'b0 || o_wb_data !== 64'h0) begin
      errors++; $display("FAIL mis_hold got v=%0b wen=%0b d=%h want 1/0/0", mem_wb_valid, o_wb_wen, o_wb_data); end
    tick();
    checks++; if (o_misalign !== 1'b0 || o_req_valid !== 1'b0 || mem_wb_valid !== 1'b1) begin
      errors++; $display("FAIL mis_one_cycle got mis=%0b req=%0b v=%0b want 0/0/1", o_misalign, o_req_valid, mem_wb_valid); end
    wb_mem_ready = 1'b1;
    tick();
    wb_mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_mem_ready = 1'b1;
    i_exu_res = 64'h11; i_mem_en = 1'b0; i_mem_opt = 4'h0; i_rd = 5'd1;
    alu_mem_valid = 1'b1;
    tick();
    checks++; if (mem_wb_valid !== 1'b1 || o_wb_data !== 64'h11 || mem_alu_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first got v=%0b d=%h rdy=%0b want 1/11/0", mem_wb_valid, o_wb_data, mem_alu_ready); end
    i_exu_res = 64'h22;
    tick();
    checks++; if (mem_wb_valid !== 1'b0 || mem_alu_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got v=%0b rdy=%0b want 0/1", mem_wb_valid, mem_alu_ready); end
    tick();
    alu_mem_valid = 1'b0;
    checks++; if (mem_wb_valid !== 1'b1 || o_wb_data !== 64'h22) begin
      errors++; $display("FAIL b2b_second got v=%0b d=%h want 1/22", mem_wb_valid, o_wb_data); end
    tick();
    wb_mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    issue(64'h300, 64'h0, 1'b1, 4'b0011, 5'd6);
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    checks++; if (mem_alu_ready !== 1'b1 || o_req_valid !== 1'b0 || mem_wb_valid !== 1'b0 || o_req_addr !== 64'h0 || o_wb_rd !== 5'd0) begin
      errors++; $display("FAIL rst_async got rdy=%0b req=%0b v=%0b addr=%h rd=%0d want 1/0/0/0/0",
                         mem_alu_ready, o_req_valid, mem_wb_valid, o_req_addr, o_wb_rd); end
    tick();
    i_rst = 1'b0;
    i_rsp_valid = 1'b1; i_rsp_rdata = 64'hDEAD;
    tick();
    i_rsp_valid = 1'b0;
    tick();
    checks++; if (mem_wb_valid !== 1'b0 || mem_alu_ready !== 1'b1 || o_wb_data !== 64'h0) begin
      errors++; $display("FAIL rst_late_rsp got v=%0b rdy=%0b d=%h want 0/1/0", mem_wb_valid, mem_alu_ready, o_wb_data); end
  endtask

  initial begin
    i_rst = 1'b1; alu_mem_valid = 1'b0; i_exu_res = '0; i_rs2 = '0; i_mem_en = 1'b0;
    i_mem_opt = '0; i_rd = '0; i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_rdata = '0;
    wb_mem_ready = 1'b0;
    tick();
    tick();
    test_reset();
    i_rst = 1'b0;
    tick();
    test_passthrough();
    test_loads();
    test_stores();
    test_backpressure();
    test_misalign();
    test_back_to_back();
    test_reset_mid_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
